// File: rtl/ex_muldiv_unit.sv
// rtl/ex_muldiv_unit.sv - iterative RV32M multiply/divide unit for the EX stage
// Optional single-cycle multiply when MULDIV_FAST_MUL_EN is defined.
module ex_muldiv_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [2:0]  funct3,
    input  logic [31:0] rs1,
    input  logic [31:0] rs2,
    input  logic        flush,
    output logic [31:0] result,
    output logic        done,
    output logic        busy,
    output logic        stall
);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIN} state_t;

    state_t      r_state;
    logic [4:0]  r_cnt;
    logic [2:0]  r_op;
    logic [31:0] r_b;
    logic [63:0] r_acc;
    logic        r_neg_q;
    logic        r_neg_r;
    logic        r_bypass;
    logic [31:0] r_byp_val;
    logic [31:0] r_result;
    logic        r_done;

    logic        w_accept;
    logic        w_is_div;
    logic        w_sa;
    logic        w_sb;
    logic        w_neg_a;
    logic        w_neg_b;
    logic [31:0] w_mag_a;
    logic [31:0] w_mag_b;
    logic        w_div0;
    logic        w_ovf;
    logic [31:0] w_byp_val;
    logic [32:0] w_msum;
    logic [63:0] w_mstep;
    logic [32:0] w_rsh;
    logic [32:0] w_diff;
    logic [63:0] w_dstep;
    logic [63:0] w_prod;
    logic [31:0] w_quo;
    logic [31:0] w_rem;
    logic [31:0] w_fin;

    assign w_accept = (r_state == S_IDLE) && start && !r_done && !flush;
    assign w_is_div = funct3[2];

    // Signedness per operand: multiplies use funct3[1:0], divides use funct3[0].
    assign w_sa = w_is_div ? !funct3[0] : (funct3[1:0] != 2'b11);
    assign w_sb = w_is_div ? !funct3[0] : !funct3[1];

    assign w_neg_a = w_sa && rs1[31];
    assign w_neg_b = w_sb && rs2[31];
    assign w_mag_a = w_neg_a ? (32'd0 - rs1) : rs1;
    assign w_mag_b = w_neg_b ? (32'd0 - rs2) : rs2;

    assign w_div0    = w_is_div && (rs2 == 32'd0);
    assign w_ovf     = w_is_div && !funct3[0] && (rs1 == 32'h8000_0000) && (rs2 == 32'hFFFF_FFFF);
    assign w_byp_val = w_div0 ? (funct3[1] ? rs1 : 32'hFFFF_FFFF)
                              : (funct3[1] ? 32'd0 : 32'h8000_0000);

`ifdef MULDIV_FAST_MUL_EN
    logic [63:0] w_fast_prod;
    assign w_fast_prod = $signed({w_sa && rs1[31], rs1}) * $signed({w_sb && rs2[31], rs2});
`endif

    // Shift-add multiply: r_acc = {hi, multiplier}, multiplicand in r_b.
    assign w_msum  = {1'b0, r_acc[63:32]} + (r_acc[0] ? {1'b0, r_b} : 33'd0);
    assign w_mstep = {w_msum, r_acc[31:1]};

    // Restoring divide: r_acc = {remainder, dividend/quotient}, divisor in r_b.
    assign w_rsh   = r_acc[63:31];
    assign w_diff  = w_rsh - {1'b0, r_b};
    assign w_dstep = w_diff[32] ? {w_rsh[31:0], r_acc[30:0], 1'b0}
                                : {w_diff[31:0], r_acc[30:0], 1'b1};

    assign w_prod = r_neg_q ? (64'd0 - r_acc) : r_acc;
    assign w_quo  = r_neg_q ? (32'd0 - r_acc[31:0]) : r_acc[31:0];
    assign w_rem  = r_neg_r ? (32'd0 - r_acc[63:32]) : r_acc[63:32];

    always_comb begin
        w_fin = 32'd0;
        if (r_bypass)
            w_fin = r_byp_val;
        else if (r_op[2])
            w_fin = r_op[1] ? w_rem : w_quo;
        else
            w_fin = (r_op[1:0] == 2'b00) ? w_prod[31:0] : w_prod[63:32];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= 5'd0;
            r_op      <= 3'd0;
            r_b       <= 32'd0;
            r_acc     <= 64'd0;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
            r_bypass  <= 1'b0;
            r_byp_val <= 32'd0;
            r_result  <= 32'd0;
            r_done    <= 1'b0;
        end else if (flush) begin
            r_state <= S_IDLE;
            r_cnt   <= 5'd0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_op      <= funct3;
                        r_cnt     <= 5'd0;
                        r_bypass  <= w_div0 || w_ovf;
                        r_byp_val <= w_byp_val;
                        r_neg_r   <= w_neg_a;
                        if (w_is_div) begin
                            r_acc   <= {32'd0, w_mag_a};
                            r_b     <= w_mag_b;
                            r_neg_q <= w_neg_a ^ w_neg_b;
                            r_state <= (w_div0 || w_ovf) ? S_FIN : S_CALC;
                        end else begin
`ifdef MULDIV_FAST_MUL_EN
                            r_acc   <= w_fast_prod;
                            r_b     <= w_mag_a;
                            r_neg_q <= 1'b0;
                            r_state <= S_FIN;
`else
                            r_acc   <= {32'd0, w_mag_b};
                            r_b     <= w_mag_a;
                            r_neg_q <= w_neg_a ^ w_neg_b;
                            r_state <= S_CALC;
`endif
                        end
                    end
                end
                S_CALC: begin
                    r_acc <= r_op[2] ? w_dstep : w_mstep;
                    r_cnt <= r_cnt + 5'd1;
                    if (r_cnt == 5'd31)
                        r_state <= S_FIN;
                end
                S_FIN: begin
                    r_result <= w_fin;
                    r_done   <= 1'b1;
                    r_state  <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign result = r_result;
    assign done   = r_done;
    assign busy   = (r_state != S_IDLE);
    assign stall  = busy || (start && !r_done);

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// tb/tb_ex_muldiv_unit.sv - directed vector bench for ex_muldiv_unit
module tb_ex_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic        flush;
    logic [31:0] result;
    logic        done;
    logic        busy;
    logic        stall;

    ex_muldiv_unit dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .funct3 (funct3),
        .rs1    (rs1),
        .rs2    (rs2),
        .flush  (flush),
        .result (result),
        .done   (done),
        .busy   (busy),
        .stall  (stall)
    );

    always #5 clk = ~clk;

`ifdef MULDIV_FAST_MUL_EN
    localparam int ML = 1;
`else
    localparam int ML = 33;
`endif
    localparam int DL = 33;

    localparam logic [2:0] MUL = 3'd0, MULH = 3'd1, MULHSU = 3'd2, MULHU = 3'd3;
    localparam logic [2:0] DIV = 3'd4, DIVU = 3'd5, REM = 3'd6, REMU = 3'd7;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[24];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one op from idle, scramble operands after acceptance, wait for done.
    task automatic run_op(input string name, input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int lat);
        int cyc;
        logic stall_ok;
        stall_ok = 1'b1;
        funct3 = f;
        rs1    = a;
        rs2    = b;
        start  = 1'b1;
        #1;
        if (!stall) stall_ok = 1'b0;
        @(posedge clk);
        #1;
        start  = 1'b0;
        rs1    = $urandom;
        rs2    = $urandom;
        funct3 = 3'($urandom);
        cyc    = 0;
        while (!done && cyc < 100) begin
            if (!stall) stall_ok = 1'b0;
            tick();
            cyc++;
        end
        chk({name, "_result"}, result, exp);
        chk({name, "_latency"}, cyc, lat);
        chk({name, "_stall"}, {31'd0, stall_ok}, 32'd1);
        tick();
        chk({name, "_done_drop"}, {31'd0, done}, 32'd0);
    endtask

    initial begin
        int dcount;
        int cyc;
        logic stall_ok;

        vecs[0]  = '{MUL,    32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, ML};
        vecs[1]  = '{MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, ML};
        vecs[2]  = '{MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, ML};
        vecs[3]  = '{MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, ML};
        vecs[4]  = '{DIV,    32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, DL};
        vecs[5]  = '{REM,    32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, DL};
        vecs[6]  = '{DIVU,   32'hFFFF_FFF9, 32'h0000_0002, 32'h7FFF_FFFC, DL};
        vecs[7]  = '{DIV,    32'h0000_0005, 32'h0000_0000, 32'hFFFF_FFFF, 1};
        vecs[8]  = '{REMU,   32'h0000_1234, 32'h0000_0000, 32'h0000_1234, 1};
        vecs[9]  = '{DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1};
        vecs[10] = '{REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1};
        vecs[11] = '{DIVU,   32'h0000_0064, 32'h0000_0000, 32'hFFFF_FFFF, 1};
        vecs[12] = '{REM,    32'h0000_0055, 32'h0000_0000, 32'h0000_0055, 1};
        vecs[13] = '{MUL,    32'h1234_5678, 32'h0000_0010, 32'h2345_6780, ML};
        vecs[14] = '{MULHU,  32'h1234_5678, 32'h0000_0010, 32'h0000_0001, ML};
        vecs[15] = '{REM,    32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, DL};
        vecs[16] = '{DIV,    32'h0000_0007, 32'hFFFF_FFFE, 32'hFFFF_FFFD, DL};
        vecs[17] = '{REMU,   32'h0000_0064, 32'h0000_0007, 32'h0000_0002, DL};
        vecs[18] = '{DIVU,   32'h0000_0064, 32'h0000_0007, 32'h0000_000E, DL};
        vecs[19] = '{MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, ML};
        vecs[20] = '{MULH,   32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF, ML};
        vecs[21] = '{DIV,    32'h8000_0000, 32'h0000_0002, 32'hC000_0000, DL};
        vecs[22] = '{MULHSU, 32'h8000_0000, 32'h8000_0000, 32'hC000_0000, ML};
        vecs[23] = '{DIVU,   32'h0000_0064, 32'h0000_0007, 32'h0000_000E, DL};

        rst    = 1'b1;
        start  = 1'b0;
        flush  = 1'b0;
        funct3 = 3'd0;
        rs1    = 32'd0;
        rs2    = 32'd0;
        repeat (3) tick();
        chk("reset_result", result, 32'd0);
        chk("reset_done", {31'd0, done}, 32'd0);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_stall", {31'd0, stall}, 32'd0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 24; i++)
            run_op($sformatf("v%0d", i), vecs[i].f, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat);

        // Flush in the 10th cycle of a divide; result must keep 0x0E from the last vector.
        funct3 = DIV; rs1 = 32'd100; rs2 = 32'd3; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (9) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_busy", {31'd0, busy}, 32'd0);
        chk("flush_done", {31'd0, done}, 32'd0);
        chk("flush_result", result, 32'h0000_000E);
        dcount = 0;
        repeat (3) begin
            if (done) dcount++;
            tick();
        end
        chk("flush_no_done", dcount, 0);
        run_op("after_flush", DIV, 32'd100, 32'd3, 32'h0000_0021, DL);

        // Reset in the 5th cycle of MULHU aborts silently.
        funct3 = MULHU; rs1 = 32'hFFFF_FFFF; rs2 = 32'hFFFF_FFFF; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        rst = 1'b1;
        tick();
        chk("midrst_result", result, 32'd0);
        chk("midrst_done", {31'd0, done}, 32'd0);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_stall", {31'd0, stall}, 32'd0);
        rst = 1'b0;
        dcount = 0;
        repeat (40) begin
            if (done || busy) dcount++;
            tick();
        end
        chk("midrst_silent", dcount, 0);

        // start held high through the done cycle gives exactly one completion.
        funct3 = MUL; rs1 = 32'd7; rs2 = 32'hFFFF_FFFD; start = 1'b1;
        stall_ok = 1'b1;
        tick();
        cyc = 0;
        while (!done && cyc < 100) begin
            if (!stall) stall_ok = 1'b0;
            tick();
            cyc++;
        end
        chk("held_latency", cyc, ML);
        chk("held_result", result, 32'hFFFF_FFEB);
        chk("held_stall", {31'd0, stall_ok}, 32'd1);
        chk("held_stall_done_cycle", {31'd0, stall}, 32'd0);
        tick();
        start = 1'b0;
        chk("held_no_reissue", {31'd0, busy}, 32'd0);
        dcount = 0;
        repeat (40) begin
            if (done) dcount++;
            tick();
        end
        chk("held_one_done", dcount, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
